// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_pkg
// Description : Shared types and constants for the modular exponentiation engine
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TOM_M   = 3'd1,
        S_TOM_ONE = 3'd2,
        S_SQR     = 3'd3,
        S_MUL     = 3'd4,
        S_FROM_M  = 3'd5,
        S_DONE    = 3'd6
    } rsa_state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_P_ZERO = 2'd1;
    localparam logic [1:0] ERR_P_EVEN = 2'd2;
    localparam logic [1:0] ERR_M_GE_P = 2'd3;

    // Clock cycles consumed by one Montgomery product (issue + iterations + reduce)
    function automatic int mm_cycles(input int width);
        return width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_mont_mult.sv
`default_nettype none
// ============================================================================
// Module      : rsa_mont_mult
// Description : Bit-serial Montgomery product s = a*b*2^-WIDTH mod p, WIDTH+2 cycles
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_mont_mult #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             done,
    output logic [WIDTH-1:0] s
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH+1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic             r_red;

    logic [WIDTH+1:0] w_sum;
    logic [WIDTH+1:0] w_tot;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Partial sum stays below 4p, so WIDTH+2 bits never overflow
    assign w_sum  = r_s + (r_a[0] ? {2'b00, r_b} : '0);
    assign w_tot  = w_sum + (w_sum[0] ? {2'b00, r_p} : '0);
    assign w_ge   = (r_s >= {2'b00, r_p});
    assign w_diff = r_s[WIDTH-1:0] - r_p;

    assign done = r_red;
    assign s    = w_ge ? w_diff : r_s[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_s   <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
            r_red <= 1'b0;
        end else if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_p   <= p;
            r_s   <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
            r_red <= 1'b0;
        end else if (r_run) begin
            r_s   <= w_tot >> 1;
            r_a   <= r_a >> 1;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_run <= 1'b0;
                r_red <= 1'b1;
            end
        end else begin
            r_red <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rsa_modexp_engine.sv
`default_nettype none
// ============================================================================
// Module      : rsa_modexp_engine
// Description : C = M^E mod P via Montgomery square-and-multiply (MSB first).
//               Optional RSA_MODEXP_ZERO_SKIP_EN starts at the exponent's top set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             eoc,
    output logic             valid,
    output logic             err
);

    rsa_state_e       r_state;
    rsa_state_e       w_state_nx;

    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_a;
    logic [IDX_W-1:0] r_idx;
    logic             r_issue;
    logic             r_bad;
    logic [WIDTH-1:0] r_c;
    logic             r_busy;
    logic             r_eoc;
    logic             r_valid;
    logic             r_err;

    logic [1:0]       w_code;
    logic             w_accept;
    logic             w_mm_go;
    logic             w_issue_nx;
    logic             w_ld_x;
    logic             w_ld_a;
    logic             w_idx_init;
    logic             w_idx_dec;
    logic             w_finish;
    logic             w_abort;
    logic             w_clear;
    logic [IDX_W-1:0] w_idx_start;
    logic [WIDTH-1:0] w_mm_a;
    logic [WIDTH-1:0] w_mm_b;
    logic [WIDTH-1:0] w_mm_p;
    logic             w_mm_start;
    logic             w_mm_done;
    logic [WIDTH-1:0] w_mm_s;

    always_comb begin
        if (p == '0)
            w_code = ERR_P_ZERO;
        else if (!p[0])
            w_code = ERR_P_EVEN;
        else if (m >= p)
            w_code = ERR_M_GE_P;
        else
            w_code = ERR_NONE;
    end

`ifdef RSA_MODEXP_ZERO_SKIP_EN
    logic [IDX_W-1:0] w_msb;

    always_comb begin
        w_msb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_e[i])
                w_msb = IDX_W'(i);
        end
    end

    assign w_idx_start = w_msb;
`else
    assign w_idx_start = IDX_W'(WIDTH - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_mm_go    = 1'b0;
        w_issue_nx = 1'b0;
        w_ld_x     = 1'b0;
        w_ld_a     = 1'b0;
        w_idx_init = 1'b0;
        w_idx_dec  = 1'b0;
        w_finish   = 1'b0;
        w_abort    = 1'b0;
        w_clear    = 1'b0;
        w_mm_a     = r_a;
        w_mm_b     = r_a;
        w_mm_p     = r_p;

        case (r_state)
            S_IDLE: begin
                // First product is issued straight from the ports in the accept cycle
                w_mm_a = m;
                w_mm_b = r2;
                w_mm_p = p;
                if (clear) begin
                    w_clear = 1'b1;
                end else if (start) begin
                    w_accept = 1'b1;
                    if (w_code == ERR_NONE) begin
                        w_mm_go    = 1'b1;
                        w_state_nx = S_TOM_M;
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_TOM_M: begin
                if (w_mm_done) begin
                    w_ld_x     = 1'b1;
                    w_issue_nx = 1'b1;
                    w_state_nx = S_TOM_ONE;
                end
            end
            S_TOM_ONE: begin
                w_mm_a = WIDTH'(1);
                w_mm_b = r_r2;
                if (w_mm_done) begin
                    w_ld_a     = 1'b1;
                    w_issue_nx = 1'b1;
`ifdef RSA_MODEXP_ZERO_SKIP_EN
                    if (r_e == '0) begin
                        w_state_nx = S_FROM_M;
                    end else begin
                        w_idx_init = 1'b1;
                        w_state_nx = S_MUL;
                    end
`else
                    w_idx_init = 1'b1;
                    w_state_nx = S_SQR;
`endif
                end
            end
            S_SQR: begin
                if (w_mm_done) begin
                    w_ld_a     = 1'b1;
                    w_issue_nx = 1'b1;
                    if (r_e[r_idx]) begin
                        w_state_nx = S_MUL;
                    end else if (r_idx == '0) begin
                        w_state_nx = S_FROM_M;
                    end else begin
                        w_idx_dec  = 1'b1;
                        w_state_nx = S_SQR;
                    end
                end
            end
            S_MUL: begin
                w_mm_b = r_x;
                if (w_mm_done) begin
                    w_ld_a     = 1'b1;
                    w_issue_nx = 1'b1;
                    if (r_idx == '0) begin
                        w_state_nx = S_FROM_M;
                    end else begin
                        w_idx_dec  = 1'b1;
                        w_state_nx = S_SQR;
                    end
                end
            end
            S_FROM_M: begin
                w_mm_b = WIDTH'(1);
                if (w_mm_done) begin
                    w_ld_a     = 1'b1;
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_finish   = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Abort overrides every transition; rejected requests are never busy
        if (stop && r_busy && (r_state != S_IDLE)) begin
            w_abort    = 1'b1;
            w_finish   = 1'b0;
            w_issue_nx = 1'b0;
            w_state_nx = S_IDLE;
        end
    end

    assign w_mm_start = w_mm_go | r_issue;

    rsa_mont_mult #(
        .WIDTH (WIDTH)
    ) u_mont_mult (
        .clk   (clk),
        .rst   (rst),
        .start (w_mm_start),
        .a     (w_mm_a),
        .b     (w_mm_b),
        .p     (w_mm_p),
        .done  (w_mm_done),
        .s     (w_mm_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_e     <= '0;
            r_r2    <= '0;
            r_x     <= '0;
            r_a     <= '0;
            r_idx   <= '0;
            r_issue <= 1'b0;
            r_bad   <= 1'b0;
            r_c     <= '0;
            r_busy  <= 1'b0;
            r_eoc   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_issue <= w_issue_nx;
            r_eoc   <= w_finish;

            if (w_accept) begin
                r_p    <= p;
                r_e    <= e;
                r_r2   <= r2;
                r_bad  <= (w_code != ERR_NONE);
                r_busy <= (w_code == ERR_NONE);
            end

            if (w_ld_x)
                r_x <= w_mm_s;
            if (w_ld_a)
                r_a <= w_mm_s;

            if (w_idx_init)
                r_idx <= w_idx_start;
            else if (w_idx_dec)
                r_idx <= r_idx - IDX_W'(1);

            if (w_finish) begin
                r_busy <= 1'b0;
                if (r_bad) begin
                    r_c     <= '0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b1;
                end else begin
                    r_c     <= r_a;
                    r_valid <= 1'b1;
                    r_err   <= 1'b0;
                end
            end

            if (w_abort)
                r_busy <= 1'b0;

            if (w_clear) begin
                r_c     <= '0;
                r_valid <= 1'b0;
                r_err   <= 1'b0;
            end
        end
    end

    assign c     = r_c;
    assign busy  = r_busy;
    assign eoc   = r_eoc;
    assign valid = r_valid;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_modexp_engine
// Description : Directed scoreboard bench for rsa_modexp_engine at WIDTH 8 and 16
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rsa_modexp_engine;

    localparam int W  = 8;
    localparam int W2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stop, clear;
    logic [W-1:0]  p, e, m, r2, c;
    logic          busy, eoc, valid, err;

    logic          rst2, start2, stop2, clear2;
    logic [W2-1:0] p2, e2, m2, r22, c2;
    logic          busy2, eoc2, valid2, err2;

    rsa_modexp_engine #(.WIDTH(W)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .p(p), .e(e), .m(m), .r2(r2),
        .c(c), .busy(busy), .eoc(eoc), .valid(valid), .err(err)
    );

    rsa_modexp_engine #(.WIDTH(W2)) u_dut16 (
        .clk(clk), .rst(rst2), .start(start2), .stop(stop2), .clear(clear2),
        .p(p2), .e(e2), .m(m2), .r2(r22),
        .c(c2), .busy(busy2), .eoc(eoc2), .valid(valid2), .err(err2)
    );

    typedef struct {
        logic [15:0] c;
        logic        valid;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic longint ref_modexp(input longint base, input longint ex, input longint md);
        longint r, b, x;
        r = 1 % md;
        b = base % md;
        x = ex;
        while (x > 0) begin
            if (x[0]) r = (r * b) % md;
            b = (b * b) % md;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int popc(input longint v);
        int k = 0;
        for (int i = 0; i < 32; i++) if (v[i]) k++;
        return k;
    endfunction

    function automatic int lat_of(input int w, input longint ev);
        return (3 + w + popc(ev)) * (w + 2) + 1;
    endfunction

    task automatic push_exp(input logic [7:0] pp, input logic [7:0] ee, input logic [7:0] mm);
        exp_t x;
        if (pp == 8'd0 || !pp[0] || mm >= pp) begin
            x.c = 16'd0; x.valid = 1'b0; x.err = 1'b1; x.lat = 2;
        end else begin
            x.c = 16'(ref_modexp(longint'(mm), longint'(ee), longint'(pp)));
            x.valid = 1'b1; x.err = 1'b0; x.lat = lat_of(W, longint'(ee));
        end
        sb.push_back(x);
    endtask

    // inj > 0 pulses a second start with different operands at cycle t0+inj
    task automatic run8(input string tag, input logic [7:0] pp, input logic [7:0] ee,
                        input logic [7:0] mm, input logic [7:0] rr, input int inj);
        exp_t x;
        int   n;
        logic seen_busy;
        push_exp(pp, ee, mm);
        @(negedge clk);
        p = pp; e = ee; m = mm; r2 = rr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 1; seen_busy = busy;
        while (!eoc && n < 3000) begin
            if (n == inj) begin start = 1'b1; m = 8'd5; e = 8'd3; end
            @(posedge clk); #1;
            start = 1'b0; n++; seen_busy |= busy;
        end
        x = sb.pop_front();
        chk({tag, "_eoc"},   32'(eoc), 32'd1);
        chk({tag, "_lat"},   32'(n), 32'(x.lat));
        chk({tag, "_c"},     32'(c), 32'(x.c));
        chk({tag, "_valid"}, 32'(valid), 32'(x.valid));
        chk({tag, "_err"},   32'(err), 32'(x.err));
        chk({tag, "_busy"},  32'({seen_busy, busy}), x.err ? 32'd0 : 32'd2);
        @(posedge clk); #1;
        chk({tag, "_eocpulse"}, 32'(eoc), 32'd0);
    endtask

    initial begin
        int      n;
        logic    seen;
        longint  pp16, ee16, mm16, rr16, cref16;

        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        p = '0; e = '0; m = '0; r2 = '0;
        rst2 = 1'b1; start2 = 1'b0; stop2 = 1'b0; clear2 = 1'b0;
        p2 = '0; e2 = '0; m2 = '0; r22 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;
        @(posedge clk); #1;
        chk("reset_outs", 32'({c, busy, eoc, valid, err}), 32'd0);
        chk("reset_outs16", 32'({c2, busy2, eoc2, valid2, err2}), 32'd0);

        run8("encrypt", 8'd187, 8'd7, 8'd88, 8'd86, 0);
        run8("decrypt", 8'd187, 8'd23, 8'd11, 8'd86, 0);

        // Abort at t0+50: nothing about the previous result may change
        @(negedge clk);
        p = 8'd187; e = 8'd7; m = 8'd88; r2 = 8'd86; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 1; seen = eoc;
        while (n < 50) begin @(posedge clk); #1; n++; seen |= eoc; end
        chk("stop_busy_before", 32'(busy), 32'd1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_keep", 32'({c, valid, err}), 32'({8'd88, 1'b1, 1'b0}));
        repeat (150) begin @(posedge clk); #1; seen |= eoc; end
        chk("stop_no_eoc", 32'(seen), 32'd0);
        chk("stop_keep_late", 32'({c, valid, err, busy}), 32'({8'd88, 1'b1, 1'b0, 1'b0}));

        run8("restart_ignored", 8'd187, 8'd7, 8'd88, 8'd86, 20);

        @(negedge clk); clear = 1'b1; start = 1'b1;
        @(posedge clk); #1; clear = 1'b0; start = 1'b0;
        chk("clear_outs", 32'({c, valid, err}), 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("clear_start_ignored", 32'({busy, eoc}), 32'd0);

        run8("p_even", 8'd186, 8'd7, 8'd88, 8'd86, 0);
        run8("m_ge_p", 8'd187, 8'd7, 8'd200, 8'd86, 0);
        run8("e_zero", 8'd187, 8'd0, 8'd5, 8'd86, 0);
        run8("p_one", 8'd1, 8'd0, 8'd0, 8'd0, 0);

        // WIDTH=16 against the independent model
        pp16 = 65521; ee16 = 64'h0101; mm16 = 64'h1234;
        rr16 = (64'd1 << 32) % pp16;
        cref16 = ref_modexp(mm16, ee16, pp16);
        @(negedge clk);
        p2 = 16'(pp16); e2 = 16'(ee16); m2 = 16'(mm16); r22 = 16'(rr16); start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; n = 1;
        while (!eoc2 && n < 3000) begin @(posedge clk); #1; n++; end
        chk("w16_eoc", 32'(eoc2), 32'd1);
        chk("w16_lat", 32'(n), 32'(lat_of(W2, ee16)));
        chk("w16_c", 32'(c2), 32'(cref16));
        chk("w16_flags", 32'({valid2, err2, busy2}), 32'b100);

        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; n = 1;
        while (n < 30) begin @(posedge clk); #1; n++; end
        chk("w16_busy_mid", 32'(busy2), 32'd1);
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        chk("w16_rst_outs", 32'({c2, busy2, eoc2, valid2, err2}), 32'd0);
        seen = 1'b0;
        repeat (400) begin @(posedge clk); #1; seen |= eoc2; end
        chk("w16_rst_no_eoc", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
